// File: rtl/prf_multiport_rf.sv
// Multi-port physical register file: combinational read ports with same-cycle write bypass,
// lane writeback ports, and a byte-serial debug engine. Optional parity storage under PRF_PARITY_EN.
module prf_multiport_rf #(
    parameter int NUM_RD = 4,
    parameter int NUM_WR = 2,
    parameter int DEPTH  = 96,
    parameter int INDEX  = 7,
    parameter int WIDTH  = 64,
    localparam int BYTES = WIDTH / 8,
    localparam int OFF   = $clog2(BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*INDEX-1:0] rd_addr_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    input  logic [NUM_WR-1:0]       wr_valid_i,
    input  logic [NUM_WR*INDEX-1:0] wr_addr_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    input  logic [INDEX+OFF-1:0]    dbg_addr_i,
    input  logic [7:0]              dbg_wr_data_i,
    input  logic                    dbg_wr_en_i,
    output logic [7:0]              dbg_rd_data_o,
    output logic                    dbg_busy_o
`ifdef PRF_PARITY_EN
    ,
    output logic [NUM_RD-1:0]       rd_perr_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];
`ifdef PRF_PARITY_EN
    logic             par [DEPTH];
`endif

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] staging_q;
    logic [INDEX-1:0] commit_entry_q;
    logic             commit;

    logic [INDEX-1:0] dbg_entry;
    logic [OFF-1:0]   dbg_off;

    assign dbg_entry = dbg_addr_i[INDEX+OFF-1:OFF];
    assign dbg_off   = dbg_addr_i[OFF-1:0];

    // A commit only happens in a cycle with no lane writes, so it never collides with them.
    assign commit = (state_q == PEND) && (wr_valid_i == '0);

    // Storage: later lanes are assigned last, so the highest lane index wins on collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef PRF_PARITY_EN
                par[i] <= 1'b0;
`endif
            end
        end else begin
            if (commit && int'(commit_entry_q) < DEPTH) begin
                mem[commit_entry_q] <= staging_q;
`ifdef PRF_PARITY_EN
                par[commit_entry_q] <= ^staging_q;
`endif
            end
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_valid_i[k] && int'(wr_addr_i[k*INDEX +: INDEX]) < DEPTH) begin
                    mem[wr_addr_i[k*INDEX +: INDEX]] <= wr_data_i[k*WIDTH +: WIDTH];
`ifdef PRF_PARITY_EN
                    par[wr_addr_i[k*INDEX +: INDEX]] <= ^wr_data_i[k*WIDTH +: WIDTH];
`endif
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [INDEX-1:0] addr;
        logic [WIDTH-1:0] data;
        logic             in_range;
        logic             hit;

        assign addr     = rd_addr_i[r*INDEX +: INDEX];
        assign in_range = int'(addr) < DEPTH;

        always_comb begin
            hit  = 1'b0;
            data = in_range ? mem[addr] : '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (in_range && wr_valid_i[k] && wr_addr_i[k*INDEX +: INDEX] == addr) begin
                    hit  = 1'b1;
                    data = wr_data_i[k*WIDTH +: WIDTH];
                end
            end
        end

        assign rd_data_o[r*WIDTH +: WIDTH] = data;
`ifdef PRF_PARITY_EN
        assign rd_perr_o[r] = in_range && !hit && (par[addr] ^ (^mem[addr]));
`endif
    end

    // Debug read sees the array as it was before this edge's writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dbg_rd_data_o <= '0;
        end else if (int'(dbg_entry) < DEPTH) begin
            dbg_rd_data_o <= mem[dbg_entry][{dbg_off, 3'b000} +: 8];
        end else begin
            dbg_rd_data_o <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (dbg_wr_en_i && dbg_off == OFF'(BYTES - 1)) state_d = PEND;
            PEND: if (wr_valid_i == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dbg_busy_o = (state_q == PEND);
    end

    // Staging is deliberately not cleared after a commit; unwritten bytes carry over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging_q      <= '0;
            commit_entry_q <= '0;
        end else if (state_q == IDLE && dbg_wr_en_i) begin
            staging_q[{dbg_off, 3'b000} +: 8] <= dbg_wr_data_i;
            commit_entry_q                    <= dbg_entry;
        end
    end

endmodule

// File: tb/tb_prf_multiport_rf.sv
// Directed self-checking bench for prf_multiport_rf (define PRF_PARITY_EN to add the parity test).
module tb_prf_multiport_rf;

    localparam int NUM_RD = 4;
    localparam int NUM_WR = 2;
    localparam int DEPTH  = 96;
    localparam int INDEX  = 7;
    localparam int WIDTH  = 64;
    localparam int OFF    = 3;

    logic                    clk;
    logic                    reset;
    logic [NUM_RD*INDEX-1:0] rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_WR-1:0]       wr_valid;
    logic [NUM_WR*INDEX-1:0] wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic [INDEX+OFF-1:0]    dbg_addr;
    logic [7:0]              dbg_wr_data;
    logic                    dbg_wr_en;
    logic [7:0]              dbg_rd_data;
    logic                    dbg_busy;
`ifdef PRF_PARITY_EN
    logic [NUM_RD-1:0]       rd_perr;
`endif

    int checks = 0;
    int errors = 0;

    prf_multiport_rf #(
        .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rd_addr_i(rd_addr),
        .rd_data_o(rd_data),
        .wr_valid_i(wr_valid),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .dbg_addr_i(dbg_addr),
        .dbg_wr_data_i(dbg_wr_data),
        .dbg_wr_en_i(dbg_wr_en),
        .dbg_rd_data_o(dbg_rd_data),
        .dbg_busy_o(dbg_busy)
`ifdef PRF_PARITY_EN
        ,
        .rd_perr_o(rd_perr)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*INDEX +: INDEX] = INDEX'(a);
    endtask

    task automatic set_wr(input int k, input logic v, input int a, input logic [WIDTH-1:0] d);
        wr_valid[k]                 = v;
        wr_addr[k*INDEX +: INDEX]   = INDEX'(a);
        wr_data[k*WIDTH +: WIDTH]   = d;
    endtask

    task automatic set_dbg(input logic en, input int entry, input int b, input logic [7:0] d);
        dbg_wr_en   = en;
        dbg_addr    = {INDEX'(entry), OFF'(b)};
        dbg_wr_data = d;
    endtask

    function automatic logic [WIDTH-1:0] rd(input int p);
        return rd_data[p*WIDTH +: WIDTH];
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int a = 0; a < DEPTH; a++) begin
            for (int p = 0; p < NUM_RD; p++) set_rd(p, a);
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                checks++;
                if (rd(p) !== '0) begin
                    errors++;
                    $display("FAIL reset_read port %0d addr %0d got %h exp 0", p, a, rd(p));
                end
            end
        end
        checks++;
        if (dbg_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_dbg_rd got %h exp 00", dbg_rd_data);
        end
        checks++;
        if (dbg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", dbg_busy);
        end
    endtask

    task automatic test_lane_collision();
        set_wr(0, 1'b1, 5, 64'h1111);
        set_wr(1, 1'b1, 5, 64'h2222);
        set_rd(0, 5);
        #1;
        checks++;
        if (rd(0) !== 64'h2222) begin
            errors++;
            $display("FAIL collide_bypass got %h exp %h", rd(0), 64'h2222);
        end
        tick();
        set_wr(0, 1'b0, 0, '0);
        set_wr(1, 1'b0, 0, '0);
        #1;
        checks++;
        if (rd(0) !== 64'h2222) begin
            errors++;
            $display("FAIL collide_stored got %h exp %h", rd(0), 64'h2222);
        end
    endtask

    task automatic test_bypass();
        set_wr(0, 1'b1, 10, 64'hDEAD_BEEF_0000_0001);
        set_rd(2, 10);
        set_rd(3, 11);
        #1;
        checks++;
        if (rd(2) !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL bypass_lane0 got %h exp %h", rd(2), 64'hDEAD_BEEF_0000_0001);
        end
        checks++;
        if (rd(3) !== 64'h0) begin
            errors++;
            $display("FAIL bypass_other_addr got %h exp 0", rd(3));
        end
        tick();
        // Out-of-range write must be dropped and the address must read 0
        set_wr(0, 1'b0, 0, '0);
        set_wr(1, 1'b1, 100, 64'hFFFF);
        tick();
        set_wr(1, 1'b0, 0, '0);
        set_rd(1, 100);
        #1;
        checks++;
        if (rd(1) !== 64'h0) begin
            errors++;
            $display("FAIL out_of_range_read got %h exp 0", rd(1));
        end
    endtask

    task automatic test_debug_read();
        set_wr(0, 1'b1, 9, 64'hA5);
        tick();
        set_wr(0, 1'b0, 0, '0);
        set_dbg(1'b0, 9, 0, 8'h00);
        tick();
        checks++;
        if (dbg_rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL dbg_rd_byte0 got %h exp a5", dbg_rd_data);
        end
        set_dbg(1'b0, 9, 1, 8'h00);
        tick();
        checks++;
        if (dbg_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL dbg_rd_byte1 got %h exp 00", dbg_rd_data);
        end
        // Same-cycle lane write is not bypassed into the debug read
        set_wr(0, 1'b1, 9, 64'h77);
        set_dbg(1'b0, 9, 0, 8'h00);
        tick();
        set_wr(0, 1'b0, 0, '0);
        checks++;
        if (dbg_rd_data !== 8'hA5) begin
            errors++;
            $display("FAIL dbg_rd_no_bypass got %h exp a5", dbg_rd_data);
        end
        tick();
        checks++;
        if (dbg_rd_data !== 8'h77) begin
            errors++;
            $display("FAIL dbg_rd_after_write got %h exp 77", dbg_rd_data);
        end
    endtask

    task automatic test_debug_write();
        for (int b = 0; b < 7; b++) begin
            set_dbg(1'b1, 3, b, 8'(b + 1));
            tick();
            checks++;
            if (dbg_busy !== 1'b0) begin
                errors++;
                $display("FAIL dbg_wr_busy_early byte %0d got %b exp 0", b, dbg_busy);
            end
        end
        set_dbg(1'b1, 3, 7, 8'h08);
        tick();
        // Lane write pending holds the commit off; debug strobes here are dropped
        set_dbg(1'b1, 3, 0, 8'hFF);
        set_wr(0, 1'b1, 20, 64'h55);
        set_rd(0, 3);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (dbg_busy !== 1'b1) begin
                errors++;
                $display("FAIL dbg_busy_held cycle %0d got %b exp 1", c, dbg_busy);
            end
            tick();
        end
        set_wr(0, 1'b0, 0, '0);
        #1;
        checks++;
        if (rd(0) !== 64'h0) begin
            errors++;
            $display("FAIL dbg_no_early_commit got %h exp 0", rd(0));
        end
        tick();
        set_dbg(1'b0, 0, 0, 8'h00);
        #1;
        checks++;
        if (dbg_busy !== 1'b0) begin
            errors++;
            $display("FAIL dbg_busy_cleared got %b exp 0", dbg_busy);
        end
        checks++;
        if (rd(0) !== 64'h0807060504030201) begin
            errors++;
            $display("FAIL dbg_commit got %h exp %h", rd(0), 64'h0807060504030201);
        end
        set_rd(1, 20);
        #1;
        checks++;
        if (rd(1) !== 64'h55) begin
            errors++;
            $display("FAIL lane_write_during_pend got %h exp 55", rd(1));
        end
        // Only the last byte rewritten: staging keeps the earlier bytes
        set_dbg(1'b1, 4, 7, 8'h80);
        tick();
        set_dbg(1'b0, 0, 0, 8'h00);
        tick();
        set_rd(2, 4);
        #1;
        checks++;
        if (rd(2) !== 64'h8007060504030201) begin
            errors++;
            $display("FAIL dbg_staging_kept got %h exp %h", rd(2), 64'h8007060504030201);
        end
    endtask

    task automatic test_reset_in_pend();
        for (int b = 0; b < 8; b++) begin
            set_dbg(1'b1, 6, b, 8'(8'hC0 + b));
            tick();
        end
        set_dbg(1'b0, 0, 0, 8'h00);
        set_wr(0, 1'b1, 21, 64'h9);
        #1;
        checks++;
        if (dbg_busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_before_reset got %b exp 1", dbg_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dbg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_pend_busy got %b exp 0", dbg_busy);
        end
        set_wr(0, 1'b0, 0, '0);
        #1;
        reset = 1'b0;
        tick();
        set_rd(0, 6);
        set_rd(1, 3);
        #1;
        checks++;
        if (dbg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_pend_idle got %b exp 0", dbg_busy);
        end
        checks++;
        if (rd(0) !== 64'h0) begin
            errors++;
            $display("FAIL reset_in_pend_no_commit got %h exp 0", rd(0));
        end
        checks++;
        if (rd(1) !== 64'h0) begin
            errors++;
            $display("FAIL reset_in_pend_entry3 got %h exp 0", rd(1));
        end
        // Staging was cleared by reset, so a single top byte commits alone
        set_dbg(1'b1, 2, 7, 8'h11);
        tick();
        set_dbg(1'b0, 0, 0, 8'h00);
        tick();
        set_rd(2, 2);
        #1;
        checks++;
        if (rd(2) !== 64'h1100000000000000) begin
            errors++;
            $display("FAIL staging_reset got %h exp %h", rd(2), 64'h1100000000000000);
        end
    endtask

`ifdef PRF_PARITY_EN
    task automatic test_parity();
        set_wr(0, 1'b1, 7, 64'h1);
        tick();
        set_wr(0, 1'b0, 0, '0);
        set_rd(0, 7);
        set_rd(1, 8);
        #1;
        checks++;
        if (rd_perr[0] !== 1'b0) begin
            errors++;
            $display("FAIL parity_clean got %b exp 0", rd_perr[0]);
        end
        force dut.mem[7] = 64'h3;
        #1;
        checks++;
        if (rd_perr[0] !== 1'b1) begin
            errors++;
            $display("FAIL parity_flip got %b exp 1", rd_perr[0]);
        end
        checks++;
        if (rd_perr[1] !== 1'b0) begin
            errors++;
            $display("FAIL parity_other got %b exp 0", rd_perr[1]);
        end
        release dut.mem[7];
    endtask
`endif

    initial begin
        reset       = 1'b1;
        rd_addr     = '0;
        wr_valid    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        dbg_addr    = '0;
        dbg_wr_data = '0;
        dbg_wr_en   = 1'b0;
        apply_reset();

        test_reset();
        test_lane_collision();
        test_bypass();
        test_debug_read();
        test_debug_write();
        test_reset_in_pend();
`ifdef PRF_PARITY_EN
        test_parity();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
